// File: rtl/win_pkg.sv
// Shared definitions for the streaming 3x3 window generator: border modes,
// controller states and tap positions inside the packed window bus.
package win_pkg;

    localparam int BORDER_ZERO = 0;
    localparam int BORDER_REPL = 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Tap slot numbers in out_win, p11 (top-left) in the least significant slot
    localparam int P11 = 0;
    localparam int P12 = 1;
    localparam int P13 = 2;
    localparam int P21 = 3;
    localparam int P22 = 4;
    localparam int P23 = 5;
    localparam int P31 = 6;
    localparam int P32 = 7;
    localparam int P33 = 8;

endpackage

// File: rtl/line_buffer.sv
// One image line of storage. The read is asynchronous, so reading and writing
// the same address in one cycle returns the pixel stored one line earlier.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/window_gen_3x3_stream.sv
// Streaming 3x3 neighbourhood generator: one window per accepted pixel, centred
// IMG_W+1 pixels behind the input, with zero or edge-replicate border handling.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FILL  | take the first IMG_W+1 pixels of a frame, no windows yet
//   RUN   | every accepted pixel emits the window IMG_W+1 pixels back
//   FLUSH | input closed, emit the last IMG_W+1 windows, then back to FILL
module window_gen_3x3_stream
    import win_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int BORDER_MODE = BORDER_ZERO
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [9*DATA_W-1:0]      out_win,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic                     out_last
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_PEN = ROW_W'(IMG_H - 2);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_PEN = COL_W'(IMG_W - 2);

    state_t              state_q;
    state_t              state_d;
    logic                started_q;
    logic [COL_W-1:0]    ptr_q;
    logic                fill_row1_q;
    logic [ROW_W-1:0]    ctr_row_q;
    logic [COL_W-1:0]    ctr_col_q;

    logic                in_acc;
    logic                flush_step;
    logic                step;
    logic                load;
    logic                frame_done;

    logic [DATA_W-1:0]   lb1_rd;
    logic [DATA_W-1:0]   lb2_rd;
    logic [DATA_W-1:0]   sr_l [3];
    logic [DATA_W-1:0]   sr_m [3];
    logic [DATA_W-1:0]   col_r [3];
    logic [DATA_W-1:0]   raw [3][3];
    logic [DATA_W-1:0]   tap [3][3];
    logic [9*DATA_W-1:0] win_flat;
    logic                at_top;
    logic                at_bot;
    logic                at_left;
    logic                at_right;
    int                  sel_r;
    int                  sel_c;

    // Cascaded lines: lb1 yields the pixel one line up, lb2 two lines up.
    // In FLUSH nothing is written, so the pointer keeps replaying the last two lines.
    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (in_acc),
        .wr_addr (ptr_q),
        .wr_data (in_data),
        .rd_addr (ptr_q),
        .rd_data (lb1_rd)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb2 (
        .clk     (clk),
        .wr_en   (in_acc),
        .wr_addr (ptr_q),
        .wr_data (lb1_rd),
        .rd_addr (ptr_q),
        .rd_data (lb2_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (in_acc && fill_row1_q && ptr_q == '0) state_d = RUN;
            RUN:     if (in_acc && ctr_row_q == ROW_PEN && ctr_col_q == COL_PEN) state_d = FLUSH;
            FLUSH:   if (frame_done) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        flush_step = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            FILL:    in_ready = started_q;
            RUN:     in_ready = started_q && (!out_valid || out_ready);
            FLUSH: begin
                // out_last parks the flush until the final window has gone
                flush_step = (!out_valid || out_ready) && !out_last;
                frame_done = out_valid && out_ready && out_last;
            end
            default: in_ready = 1'b0;
        endcase
        in_acc = in_valid && in_ready;
        step   = in_acc || flush_step;
        load   = step && (state_q != FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q   <= 1'b0;
            ptr_q       <= '0;
            fill_row1_q <= 1'b0;
            ctr_row_q   <= '0;
            ctr_col_q   <= '0;
        end else begin
            started_q <= 1'b1;
            if (frame_done) begin
                ptr_q       <= '0;
                fill_row1_q <= 1'b0;
                ctr_row_q   <= '0;
                ctr_col_q   <= '0;
            end else if (step) begin
                ptr_q <= (ptr_q == COL_MAX) ? '0 : ptr_q + 1'b1;
                if (state_q == FILL && ptr_q == COL_MAX) begin
                    fill_row1_q <= 1'b1;
                end
                if (load) begin
                    if (ctr_col_q == COL_MAX) begin
                        ctr_col_q <= '0;
                        ctr_row_q <= (ctr_row_q == ROW_MAX) ? '0 : ctr_row_q + 1'b1;
                    end else begin
                        ctr_col_q <= ctr_col_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                sr_l[i] <= '0;
                sr_m[i] <= '0;
            end
        end else if (step) begin
            for (int i = 0; i < 3; i++) begin
                sr_l[i] <= sr_m[i];
                sr_m[i] <= col_r[i];
            end
        end
    end

    // Window centred on (ctr_row_q, ctr_col_q); edge taps are redirected to the
    // centre row/column, which replicates in mode 1 and marks the tap for zeroing in mode 0.
    always_comb begin
        col_r[0] = lb2_rd;
        col_r[1] = lb1_rd;
        col_r[2] = (state_q == FLUSH) ? '0 : in_data;
        at_top   = (ctr_row_q == '0);
        at_bot   = (ctr_row_q == ROW_MAX);
        at_left  = (ctr_col_q == '0);
        at_right = (ctr_col_q == COL_MAX);
        sel_r    = 0;
        sel_c    = 0;
        win_flat = '0;
        for (int dr = 0; dr < 3; dr++) begin
            raw[dr][0] = sr_l[dr];
            raw[dr][1] = sr_m[dr];
            raw[dr][2] = col_r[dr];
        end
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                sel_r = ((dr == 0 && at_top)  || (dr == 2 && at_bot))   ? 1 : dr;
                sel_c = ((dc == 0 && at_left) || (dc == 2 && at_right)) ? 1 : dc;
                if (BORDER_MODE == BORDER_REPL) begin
                    tap[dr][dc] = raw[sel_r][sel_c];
                end else begin
                    tap[dr][dc] = (sel_r != dr || sel_c != dc) ? '0 : raw[dr][dc];
                end
            end
        end
        win_flat[P11*DATA_W +: DATA_W] = tap[0][0];
        win_flat[P12*DATA_W +: DATA_W] = tap[0][1];
        win_flat[P13*DATA_W +: DATA_W] = tap[0][2];
        win_flat[P21*DATA_W +: DATA_W] = tap[1][0];
        win_flat[P22*DATA_W +: DATA_W] = tap[1][1];
        win_flat[P23*DATA_W +: DATA_W] = tap[1][2];
        win_flat[P31*DATA_W +: DATA_W] = tap[2][0];
        win_flat[P32*DATA_W +: DATA_W] = tap[2][1];
        win_flat[P33*DATA_W +: DATA_W] = tap[2][2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_win   <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_win   <= win_flat;
            out_row   <= ctr_row_q;
            out_col   <= ctr_col_q;
            out_last  <= (ctr_row_q == ROW_MAX) && (ctr_col_q == COL_MAX);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_gen_3x3_stream.sv
// Bench for window_gen_3x3_stream: a zero-padding and a replicate instance on a
// 4x4 image, compared every cycle against a frame-array reference model.
module tb_window_gen_3x3_stream;
    import win_pkg::*;

    localparam int DW   = 8;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int NPIX = IW * IH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   in_data = '0;

    logic            in_ready0, in_ready1;
    logic            out_valid0, out_valid1;
    logic [9*DW-1:0] out_win0, out_win1;
    logic [1:0]      out_row0, out_row1;
    logic [1:0]      out_col0, out_col1;
    logic            out_last0, out_last1;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0]   pix [NPIX];
    logic [9*DW-1:0] log0 [NPIX];
    logic [9*DW-1:0] log1 [NPIX];
    int acc_cnt = 0;
    int prod = 0;
    int cons = 0;
    int frames_done = 0;
    bit seq_data = 1'b0;

    always #5 clk = ~clk;

    window_gen_3x3_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .BORDER_MODE(BORDER_ZERO)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_win(out_win0),
        .out_row(out_row0), .out_col(out_col0), .out_last(out_last0)
    );

    window_gen_3x3_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .BORDER_MODE(BORDER_REPL)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_win(out_win1),
        .out_row(out_row1), .out_col(out_col1), .out_last(out_last1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference window straight from the frame array: out-of-image taps are 0
    // in mode 0, or take the clamped in-image coordinate in mode 1.
    function automatic logic [9*DW-1:0] model_win(input int mode, input int idx);
        logic [9*DW-1:0] w;
        int r, c, rr, cc;
        logic [DW-1:0] v;
        w = '0;
        r = idx / IW;
        c = idx % IW;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = r + dr - 1;
                cc = c + dc - 1;
                if (rr < 0 || rr >= IH || cc < 0 || cc >= IW) begin
                    if (mode == 0) begin
                        v = '0;
                    end else begin
                        rr = (rr < 0) ? 0 : (rr >= IH) ? IH - 1 : rr;
                        cc = (cc < 0) ? 0 : (cc >= IW) ? IW - 1 : cc;
                        v = pix[rr * IW + cc];
                    end
                end else begin
                    v = pix[rr * IW + cc];
                end
                w[(dr * 3 + dc) * DW +: DW] = v;
            end
        end
        return w;
    endfunction

    function automatic logic [9*DW-1:0] pack9(input int a11, input int a12, input int a13,
                                              input int a21, input int a22, input int a23,
                                              input int a31, input int a32, input int a33);
        return {DW'(a33), DW'(a32), DW'(a31), DW'(a23), DW'(a22), DW'(a21),
                DW'(a13), DW'(a12), DW'(a11)};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready0"},  128'(in_ready0),  128'(0));
        chk({tag, "_in_ready1"},  128'(in_ready1),  128'(0));
        chk({tag, "_out_valid0"}, 128'(out_valid0), 128'(0));
        chk({tag, "_out_valid1"}, 128'(out_valid1), 128'(0));
        chk({tag, "_out_win0"},   128'(out_win0),   128'(0));
        chk({tag, "_out_win1"},   128'(out_win1),   128'(0));
        chk({tag, "_out_row0"},   128'(out_row0),   128'(0));
        chk({tag, "_out_col1"},   128'(out_col1),   128'(0));
        chk({tag, "_out_last0"},  128'(out_last0),  128'(0));
        chk({tag, "_out_last1"},  128'(out_last1),  128'(0));
    endtask

    // One clock: drive at the falling edge, check outputs, then advance the model
    // with the transfers that the next rising edge will perform.
    task automatic cycle(input bit iv, input bit ordy);
        bit pend, exp_rdy, iacc;
        @(negedge clk);
        in_valid  = iv;
        in_data   = seq_data ? DW'(acc_cnt + 1) : DW'($urandom);
        out_ready = ordy;
        #1;
        pend    = (prod > cons);
        exp_rdy = (acc_cnt < NPIX) && ((acc_cnt <= IW) || !pend || ordy);
        iacc    = iv && exp_rdy;
        chk("out_valid_m0", 128'(out_valid0), 128'(pend));
        chk("out_valid_m1", 128'(out_valid1), 128'(pend));
        chk("in_ready_m0",  128'(in_ready0),  128'(exp_rdy));
        chk("in_ready_m1",  128'(in_ready1),  128'(exp_rdy));
        if (pend) begin
            chk("win_m0",  128'(out_win0),  128'(model_win(0, cons)));
            chk("win_m1",  128'(out_win1),  128'(model_win(1, cons)));
            chk("row_m0",  128'(out_row0),  128'(cons / IW));
            chk("col_m0",  128'(out_col0),  128'(cons % IW));
            chk("row_m1",  128'(out_row1),  128'(cons / IW));
            chk("col_m1",  128'(out_col1),  128'(cons % IW));
            chk("last_m0", 128'(out_last0), 128'(cons == NPIX - 1));
            chk("last_m1", 128'(out_last1), 128'(cons == NPIX - 1));
        end
        if (pend && ordy) begin
            log0[cons] = out_win0;
            log1[cons] = out_win1;
            cons++;
        end
        if (iacc) begin
            pix[acc_cnt] = in_data;
            if (acc_cnt >= IW + 1) prod++;
            acc_cnt++;
        end else if (acc_cnt == NPIX && prod < NPIX && (!pend || ordy)) begin
            prod++;
        end
        if (cons == NPIX) begin
            frames_done++;
            acc_cnt = 0;
            prod    = 0;
            cons    = 0;
        end
    endtask

    task automatic run_frames(input int nframes, input int vpct, input int rpct, input int budget);
        int target;
        int n;
        target = frames_done + nframes;
        n = 0;
        while (frames_done < target && n < budget) begin
            cycle($urandom_range(99) < vpct, $urandom_range(99) < rpct);
            n++;
        end
        checks++;
        assert (frames_done >= target) else begin
            failures++;
            $error("FAIL frame_timeout observed=%0d expected=%0d", frames_done, target);
        end
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Pixels 1..16, no backpressure
        seq_data = 1'b1;
        run_frames(1, 100, 100, 100);
        chk("m0_win_0_0", 128'(log0[0]),  128'(pack9(0, 0, 0, 0, 1, 2, 0, 5, 6)));
        chk("m0_win_3_3", 128'(log0[15]), 128'(pack9(11, 12, 0, 15, 16, 0, 0, 0, 0)));
        chk("m0_win_1_0", 128'(log0[4]),  128'(pack9(0, 1, 2, 0, 5, 6, 0, 9, 10)));
        chk("m0_win_1_3", 128'(log0[7]),  128'(pack9(3, 4, 0, 7, 8, 0, 11, 12, 0)));
        chk("m1_win_0_0", 128'(log1[0]),  128'(pack9(1, 1, 2, 1, 1, 2, 5, 5, 6)));
        chk("m1_win_3_3", 128'(log1[15]), 128'(pack9(11, 12, 12, 15, 16, 16, 15, 16, 16)));
        chk("m1_win_1_3", 128'(log1[7]),  128'(pack9(3, 4, 4, 7, 8, 8, 11, 12, 12)));

        // Random data with random backpressure, then back-to-back frames
        seq_data = 1'b0;
        run_frames(4, 80, 50, 600);
        run_frames(3, 100, 100, 200);
        run_frames(2, 70, 70, 400);

        // Reset part-way through a frame
        n = 0;
        while (acc_cnt < 9 && n < 60) begin
            cycle(1'b1, 1'b1);
            n++;
        end
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        #1 chk_reset_outputs("midrst_hold");
        acc_cnt = 0;
        prod    = 0;
        cons    = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frames(1, 100, 100, 100);
        run_frames(1, 60, 60, 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
